// File: rtl/vreg_pkg.sv
// Shared types and defaults for the
// parametrised vector register file.
package vreg_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } sstate_t;

  typedef enum logic {
    DIR_RD = 1'b0,
    DIR_WR = 1'b1
  } dir_t;

  localparam int NREGS_DEF = 8;
  localparam int LANES_DEF = 16;
  localparam int WIDTH_DEF = 16;

endpackage

// File: rtl/vreg_file_param_if.sv
// Bus bundle for the vector register file:
// parallel port plus element-serial port.
interface vreg_file_param_if #(
  parameter int NREGS = vreg_pkg::NREGS_DEF,
  parameter int LANES = vreg_pkg::LANES_DEF,
  parameter int WIDTH = vreg_pkg::WIDTH_DEF
);
  localparam int AW = $clog2(NREGS);
  localparam int DW = LANES * WIDTH;

  logic [AW-1:0]    Addr_p;
  logic             RD_p;
  logic             WR_p;
  logic [LANES-1:0] WrMask_p;
  logic [DW-1:0]    DataIn_p;
  logic [DW-1:0]    DataOut_p;
  logic             Start_s;
  logic             Dir_s;
  logic [AW-1:0]    Addr_s;
  logic             Valid_s;
  logic [WIDTH-1:0] DataIn_s;
  logic [WIDTH-1:0] DataOut_s;
  logic             ValidOut_s;
  logic             Busy_s;
  logic             Done_s;

  modport master (
    output Addr_p, RD_p, WR_p,
    output WrMask_p, DataIn_p,
    output Start_s, Dir_s, Addr_s,
    output Valid_s, DataIn_s,
    input  DataOut_p, DataOut_s,
    input  ValidOut_s, Busy_s, Done_s
  );

  modport slave (
    input  Addr_p, RD_p, WR_p,
    input  WrMask_p, DataIn_p,
    input  Start_s, Dir_s, Addr_s,
    input  Valid_s, DataIn_s,
    output DataOut_p, DataOut_s,
    output ValidOut_s, Busy_s, Done_s
  );

endinterface

// File: rtl/vreg_serial_ctrl.sv
// Element-serial stream controller: latches
// direction/register, walks the element index.
module vreg_serial_ctrl #(
  parameter int NREGS = vreg_pkg::NREGS_DEF,
  parameter int LANES = vreg_pkg::LANES_DEF,
  localparam int AW = $clog2(NREGS),
  localparam int EW = $clog2(LANES)
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          start_i,
  input  logic          dir_i,
  input  logic [AW-1:0] addr_i,
  input  logic          valid_i,
  output logic          rd_o,
  output logic          wr_o,
  output logic [EW-1:0] idx_o,
  output logic [AW-1:0] addr_o,
  output logic          busy_o,
  output logic          done_o
);
  import vreg_pkg::*;

  localparam logic [EW-1:0] LAST =
    EW'(LANES - 1);

  sstate_t       state_q, state_d;
  dir_t          dir_q, dir_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [EW-1:0] idx_q, idx_d;
  logic          done_q, done_d;

  // State, latched command and index registers
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      dir_q   <= DIR_RD;
      addr_q  <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  // Next state and per-element enables
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    rd_o    = 1'b0;
    wr_o    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          dir_d   = dir_t'(dir_i);
          addr_d  = addr_i;
          idx_d   = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (valid_i) begin
          rd_o = (dir_q == DIR_RD);
          wr_o = (dir_q == DIR_WR);
          if (idx_q == LAST) begin
            idx_d   = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + EW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign idx_o  = idx_q;
  assign addr_o = addr_q;
  assign busy_o = (state_q == STREAM);
  assign done_o = done_q;

endmodule

// File: rtl/vreg_file_param.sv
// Vector register file: masked parallel port
// and element-serial stream port, flop storage.
module vreg_file_param #(
  parameter int NREGS = vreg_pkg::NREGS_DEF,
  parameter int LANES = vreg_pkg::LANES_DEF,
  parameter int WIDTH = vreg_pkg::WIDTH_DEF
) (
  input logic         Clk,
  input logic         Rst,
  vreg_file_param_if.slave bus
);
  import vreg_pkg::*;

  localparam int AW = $clog2(NREGS);
  localparam int EW = $clog2(LANES);
  localparam int NE = NREGS * LANES;
  localparam int DW = LANES * WIDTH;

  logic          s_rd, s_wr;
  logic          s_busy, s_done;
  logic [EW-1:0] s_idx;
  logic [AW-1:0] s_addr;

  logic [WIDTH-1:0] mem_q [NE];
  logic [WIDTH-1:0] mem_d [NE];
  logic [DW-1:0]    pout_q, pout_d;
  logic [WIDTH-1:0] sout_q, sout_d;
  logic             vout_q;

  vreg_serial_ctrl #(
    .NREGS (NREGS),
    .LANES (LANES)
  ) u_ctrl (
    .Clk     (Clk),
    .Rst     (Rst),
    .start_i (bus.Start_s),
    .dir_i   (bus.Dir_s),
    .addr_i  (bus.Addr_s),
    .valid_i (bus.Valid_s),
    .rd_o    (s_rd),
    .wr_o    (s_wr),
    .idx_o   (s_idx),
    .addr_o  (s_addr),
    .busy_o  (s_busy),
    .done_o  (s_done)
  );

  // Storage update; serial element overrides
  // a same-cycle parallel lane write
  always_comb begin
    mem_d = mem_q;
    if (bus.WR_p) begin
      for (int l = 0; l < LANES; l++) begin
        if (bus.WrMask_p[l]) begin
          mem_d[{bus.Addr_p, EW'(l)}] =
            bus.DataIn_p[l*WIDTH +: WIDTH];
        end
      end
    end
    if (s_wr) begin
      mem_d[{s_addr, s_idx}] = bus.DataIn_s;
    end
  end

  // Read-side next values from pre-write data
  always_comb begin
    pout_d = pout_q;
    sout_d = sout_q;
    if (bus.RD_p) begin
      for (int l = 0; l < LANES; l++) begin
        pout_d[l*WIDTH +: WIDTH] =
          mem_q[{bus.Addr_p, EW'(l)}];
      end
    end
    if (s_rd) begin
      sout_d = mem_q[{s_addr, s_idx}];
    end
  end

  // Storage array with synchronous clear
  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < NE; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Registered read outputs
  always_ff @(posedge Clk) begin
    if (Rst) begin
      pout_q <= '0;
      sout_q <= '0;
      vout_q <= 1'b0;
    end else begin
      pout_q <= pout_d;
      sout_q <= sout_d;
      vout_q <= s_rd;
    end
  end

  assign bus.DataOut_p  = pout_q;
  assign bus.DataOut_s  = sout_q;
  assign bus.ValidOut_s = vout_q;
  assign bus.Busy_s     = s_busy;
  assign bus.Done_s     = s_done;

endmodule

// File: tb/tb_vreg_file_param.sv
// Scoreboard bench for vreg_file_param:
// default and 4x8x32 instances side by side.
module tb_vreg_file_param;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  vreg_file_param_if #(
    .NREGS(8), .LANES(16), .WIDTH(16)
  ) ifa ();
  vreg_file_param_if #(
    .NREGS(4), .LANES(8), .WIDTH(32)
  ) ifb ();

  vreg_file_param #(
    .NREGS(8), .LANES(16), .WIDTH(16)
  ) u_a (.Clk(Clk), .Rst(Rst), .bus(ifa));
  vreg_file_param #(
    .NREGS(4), .LANES(8), .WIDTH(32)
  ) u_b (.Clk(Clk), .Rst(Rst), .bus(ifb));

  logic [2:0]   p_addr [2];
  logic         p_rd   [2];
  logic         p_wr   [2];
  logic [15:0]  p_mask [2];
  logic [255:0] p_din  [2];
  logic         s_start[2];
  logic         s_dir  [2];
  logic [2:0]   s_addr [2];
  logic         s_valid[2];
  logic [31:0]  s_din  [2];

  assign ifa.Addr_p   = p_addr[0];
  assign ifa.RD_p     = p_rd[0];
  assign ifa.WR_p     = p_wr[0];
  assign ifa.WrMask_p = p_mask[0];
  assign ifa.DataIn_p = p_din[0];
  assign ifa.Start_s  = s_start[0];
  assign ifa.Dir_s    = s_dir[0];
  assign ifa.Addr_s   = s_addr[0];
  assign ifa.Valid_s  = s_valid[0];
  assign ifa.DataIn_s = s_din[0][15:0];

  assign ifb.Addr_p   = p_addr[1][1:0];
  assign ifb.RD_p     = p_rd[1];
  assign ifb.WR_p     = p_wr[1];
  assign ifb.WrMask_p = p_mask[1][7:0];
  assign ifb.DataIn_p = p_din[1];
  assign ifb.Start_s  = s_start[1];
  assign ifb.Dir_s    = s_dir[1];
  assign ifb.Addr_s   = s_addr[1][1:0];
  assign ifb.Valid_s  = s_valid[1];
  assign ifb.DataIn_s = s_din[1];

  logic [255:0] m_pout[2];
  logic [31:0]  m_sout[2];
  logic         m_vout[2];
  logic         m_busy[2];
  logic         m_done[2];

  assign m_pout[0] = ifa.DataOut_p;
  assign m_pout[1] = ifb.DataOut_p;
  assign m_sout[0] = {16'h0, ifa.DataOut_s};
  assign m_sout[1] = ifb.DataOut_s;
  assign m_vout[0] = ifa.ValidOut_s;
  assign m_vout[1] = ifb.ValidOut_s;
  assign m_busy[0] = ifa.Busy_s;
  assign m_busy[1] = ifb.Busy_s;
  assign m_done[0] = ifa.Done_s;
  assign m_done[1] = ifb.Done_s;

  typedef struct packed {
    logic         d;
    logic [255:0] v;
  } pexp_t;
  typedef struct packed {
    logic        d;
    logic [31:0] v;
  } sexp_t;

  pexp_t qp[$];
  sexp_t qs[$];
  sexp_t qd[$];

  task automatic check(input string name,
                       input logic [255:0] act,
                       input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t act=%h exp=%h",
               name, $time, act, exp);
    end
  endtask

  task automatic unexp(input string name,
                       input int d);
    n_tests++;
    n_fail++;
    $display("FAIL %s dut%0d unexpected t=%0t",
             name, d, $time);
  endtask

  // DUT registered RD_p one cycle earlier
  logic rdq[2];
  always @(posedge Clk) begin
    rdq[0] <= p_rd[0];
    rdq[1] <= p_rd[1];
  end

  // Monitor: pop and compare on each output
  always @(negedge Clk) begin
    pexp_t ep;
    sexp_t es;
    for (int d = 0; d < 2; d++) begin
      if (rdq[d]) begin
        if (qp.size() == 0) unexp("p_out", d);
        else begin
          ep = qp.pop_front();
          check("p_dut", 256'(d), 256'(ep.d));
          check("p_out", m_pout[d], ep.v);
        end
      end
      if (m_vout[d]) begin
        if (qs.size() == 0) unexp("s_out", d);
        else begin
          es = qs.pop_front();
          check("s_dut", 256'(d), 256'(es.d));
          check("s_out", 256'(m_sout[d]),
                256'(es.v));
        end
      end
      if (m_done[d]) begin
        if (qd.size() == 0) unexp("done", d);
        else begin
          es = qd.pop_front();
          check("done_dut", 256'(d),
                256'(es.d));
          check("done_cyc", 256'(cyc),
                256'(es.v));
        end
      end
    end
  end

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic pread(input int d,
                       input int addr,
                       input logic [255:0] exp);
    pexp_t e;
    e.d = d[0];
    e.v = exp;
    qp.push_back(e);
    p_rd[d]   = 1'b1;
    p_addr[d] = addr[2:0];
    tick();
    p_rd[d]   = 1'b0;
  endtask

  task automatic pwrite(input int d,
                        input int addr,
                        input logic [15:0] mask,
                        input logic [255:0] data);
    p_wr[d]   = 1'b1;
    p_addr[d] = addr[2:0];
    p_mask[d] = mask;
    p_din[d]  = data;
    tick();
    p_wr[d]   = 1'b0;
  endtask

  // Same-cycle read and write to one register
  task automatic prdwr(input int d,
                       input int addr,
                       input logic [255:0] data,
                       input logic [255:0] exp);
    pexp_t e;
    e.d = d[0];
    e.v = exp;
    qp.push_back(e);
    p_rd[d]   = 1'b1;
    p_wr[d]   = 1'b1;
    p_addr[d] = addr[2:0];
    p_mask[d] = 16'hFFFF;
    p_din[d]  = data;
    tick();
    p_rd[d]   = 1'b0;
    p_wr[d]   = 1'b0;
  endtask

  task automatic stream(input int d,
                        input bit dir,
                        input int addr,
                        input int lanes,
                        input logic [31:0] base,
                        input bit stall,
                        input int pw_at,
                        input logic [255:0] pwd);
    int    ns;
    int    na;
    sexp_t e;
    logic [31:0] v;
    ns = stall ? 2 * (lanes - 1) : 0;
    na = addr + 1;
    e.d = d[0];
    e.v = 32'(cyc + 1 + lanes + ns);
    qd.push_back(e);
    s_start[d] = 1'b1;
    s_dir[d]   = dir;
    s_addr[d]  = addr[2:0];
    tick();
    s_start[d] = 1'b0;
    check("busy_on", 256'(m_busy[d]), 256'(1));
    for (int k = 0; k < lanes; k++) begin
      v = base + 32'(k);
      if (d == 0) v[31:16] = 16'h0;
      s_valid[d] = 1'b1;
      s_din[d]   = v;
      if (!dir) begin
        e.v = v;
        qs.push_back(e);
      end
      if (k == pw_at) begin
        p_wr[d]   = 1'b1;
        p_addr[d] = addr[2:0];
        p_mask[d] = 16'hFFFF;
        p_din[d]  = pwd;
      end
      tick();
      s_valid[d] = 1'b0;
      p_wr[d]    = 1'b0;
      if (stall && k < lanes - 1) begin
        s_start[d] = 1'b1;
        s_dir[d]   = ~dir;
        s_addr[d]  = na[2:0];
        tick();
        s_start[d] = 1'b0;
        tick();
      end
    end
    check("busy_off", 256'(m_busy[d]), 256'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1);
  end

  localparam logic [255:0] PA =
    256'h0123456789ABCDEF;
  localparam logic [255:0] PA1 =
    256'h0123456789ABFFFF;
  localparam logic [255:0] PB = {
    32'hFEDCBA98, 32'h76543210,
    32'h00112233, 32'h44556677,
    32'h8899AABB, 32'hCCDDEEFF,
    32'h13579BDF, 32'h2468ACE0};
  localparam logic [255:0] PB1 = {
    32'hFEDCBA98, 32'h76543210,
    32'h00112233, 32'h44556677,
    32'h8899AABB, 32'hCCDDEEFF,
    32'h13579BDF, 32'hFFFFFFFF};

  initial begin
    logic [255:0] pwd;
    logic [255:0] cexp;
    for (int d = 0; d < 2; d++) begin
      p_addr[d]  = '0;
      p_rd[d]    = 1'b0;
      p_wr[d]    = 1'b0;
      p_mask[d]  = '0;
      p_din[d]   = '0;
      s_start[d] = 1'b0;
      s_dir[d]   = 1'b0;
      s_addr[d]  = '0;
      s_valid[d] = 1'b0;
      s_din[d]   = '0;
    end
    Rst = 1'b1;
    repeat (3) tick();
    Rst = 1'b0;
    tick();

    check("rst_busy", 256'(m_busy[0]), 256'(0));
    check("rst_vout", 256'(m_vout[0]), 256'(0));
    check("rst_sout", 256'(m_sout[0]), 256'(0));
    check("rst_pout", m_pout[1], 256'(0));
    for (int r = 0; r < 8; r++) pread(0, r, '0);
    for (int r = 0; r < 4; r++) pread(1, r, '0);

    stream(0, 1'b1, 0, 16, 32'hA000, 1'b0,
           -1, '0);
    stream(0, 1'b0, 0, 16, 32'hA000, 1'b0,
           -1, '0);

    pwrite(0, 2, 16'hFFFF, PA);
    pread(0, 2, PA);
    pwrite(0, 2, 16'h0001, {256{1'b1}});
    pread(0, 2, PA1);
    pwrite(0, 2, 16'h0000, '0);
    pread(0, 2, PA1);
    prdwr(0, 2, '0, PA1);
    pread(0, 2, '0);

    stream(0, 1'b0, 0, 16, 32'hA000, 1'b1,
           -1, '0);

    for (int i = 0; i < 16; i++) begin
      pwd[i*16 +: 16]  = 16'hC000 + 16'(i);
      cexp[i*16 +: 16] = (i < 5) ?
        16'hC000 + 16'(i) :
        16'h5000 + 16'(i);
    end
    stream(0, 1'b1, 3, 16, 32'h5000, 1'b0,
           5, pwd);
    pread(0, 3, cexp);

    stream(1, 1'b1, 1, 8, 32'hB0000000, 1'b0,
           -1, '0);
    stream(1, 1'b0, 1, 8, 32'hB0000000, 1'b0,
           -1, '0);
    pwrite(1, 3, 16'h00FF, PB);
    pread(1, 3, PB);
    pwrite(1, 3, 16'h0001, {256{1'b1}});
    pread(1, 3, PB1);

    s_start[0] = 1'b1;
    s_dir[0]   = 1'b1;
    s_addr[0]  = 3'd1;
    tick();
    s_start[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      s_valid[0] = 1'b1;
      s_din[0]   = 32'h7700 + 32'(k);
      tick();
    end
    Rst = 1'b1;
    tick();
    Rst        = 1'b0;
    s_valid[0] = 1'b0;
    check("abort_busy", 256'(m_busy[0]),
          256'(0));
    check("abort_done", 256'(m_done[0]),
          256'(0));
    tick();
    pread(0, 1, '0);
    pread(0, 0, '0);
    pread(0, 3, '0);
    pread(1, 1, '0);
    pread(1, 3, '0);

    repeat (3) tick();
    check("qp_empty", 256'(qp.size()), 256'(0));
    check("qs_empty", 256'(qs.size()), 256'(0));
    check("qd_empty", 256'(qd.size()), 256'(0));
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
